spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
//  SPI target (peripheral) end of the mode-0 link driven by the team's SPI controller: MSB first, 8-bit frames.
//  Oversamples external sck/cs_n/sdi in the clk_i domain, deserialises MOSI into rx bytes, and serialises queued tx bytes onto MISO.
//  Sits between the external pins and a byte-wide core-side valid/ready interface. Multi-byte bursts under one CS are supported.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser depth on sck_i, cs_n_i and sdi_i (>=2)
//  TX_FILL      8'hFF  byte shifted out when no tx byte is queued at a frame start
// PORTS
//  clk_i          in   1  system clock; sck_i frequency must be <= clk_i/(2*SYNC_STAGES+4)
//  rst_n_i        in   1  asynchronous, active-low reset
//  sck_i          in   1  serial clock from controller (idle low)
//  cs_n_i         in   1  chip select, active low
//  sdi_i          in   1  MOSI
//  sdo_o          out  1  MISO data
//  sdo_oe_o       out  1  MISO output enable (pad tristate control)
//  tx_data_i      in   8  byte to transmit
//  tx_valid_i     in   1  tx_data_i valid
//  tx_ready_o     out  1  tx holding register empty
//  rx_data_o      out  8  last complete received byte
//  rx_valid_o     out  1  one-cycle strobe: rx_data_o updated
//  tx_underrun_o  out  1  one-cycle strobe: TX_FILL substituted at a frame start
//  busy_o         out  1  synchronised CS active
// BEHAVIOUR
//  Reset: sdo_o=0, sdo_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0.
//   Internal state is cleared: bit counter=7, shift regs=0, holding register empty, synchronisers=idle (sck 0, cs_n 1).
//   Reset takes effect immediately, even mid-frame.
//  Input path: SYNC_STAGES flops per input, plus one registered copy for edge detect (sck rise/fall, cs fall/rise).
//   All edge events below refer to these synchronised detections.
//  Holding register: a write occurs when tx_valid_i & tx_ready_o; tx_ready_o then drops the next cycle.
//   tx_ready_o rises again the cycle after the holding register is loaded into the tx shift register.
//  Frame load: happens on cs fall, and on the sck fall that follows the 8th sck rise of a byte (while CS stays active).
//   If the holding register is full: shift register <= holding register; holding register becomes empty.
//   Else if a write happens in the same cycle: shift register <= tx_data_i (bypass); no underrun, tx_ready_o stays 1.
//   Else: shift register <= TX_FILL, and tx_underrun_o pulses for 1 cycle.
//   sdo_o is registered and equals shift[7] the cycle after the load. sdo_oe_o=1 from that cycle until CS rise.
//  sck rise (CS active): rx_shift <= {rx_shift[6:0], sdi_sync}; bit counter decrements 7..0.
//   On the rise where counter==0: rx_data_o <= completed byte, rx_valid_o pulses the following cycle, and the counter reloads to 7.
//   There is no rx backpressure; an unread byte is overwritten.
//  sck fall (CS active, not a frame-load fall): tx shift left by one; sdo_o <= next bit.
//  CS rise: bit counter <= 7; partial rx bits are discarded (no rx_valid); sdo_oe_o=0 and sdo_o=0 the next cycle.
//   A byte already moved into the tx shift register is dropped. The holding register is preserved.
//  sck edges while CS is inactive are ignored. A cs fall that coincides with an sck edge: the CS load wins and the sck edge is ignored.
//  State: IDLE (cs inactive) -> ACTIVE on cs fall; ACTIVE -> IDLE on cs rise. The bit counter handles sequencing within a byte.
// STRUCTURE
//  spi_pkg: SPI_WIDTH=8, SPI_BITCNT_W=3, SPI_DEFAULT_FILL=8'hFF; the controller and this block share these.
//  Sub-module spi_pin_sync: N-stage synchroniser with registered rise/fall pulse outputs, instantiated 3x (sdi uses the data output only).
//  Top holds the holding register, tx/rx shift registers, bit counter and the IDLE/ACTIVE FSM.
// TESTING
//  T1 Write 8'hA5 before CS; controller sends 8'h3C, sck=clk/16 -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C; exactly one rx_valid_o.
//  T2 No tx write; 1-byte frame -> MISO 8'hFF; tx_underrun_o pulses once, within SYNC_STAGES+2 cycles of cs_n fall.
//  T3 Write 8'h11, assert CS, write 8'h22 during byte 1; 2-byte burst MOSI 8'h01,8'h02 -> MISO 8'h11,8'h22; rx pulses carry 8'h01 then 8'h02; no underrun.
//  T4 Deassert cs_n after 5 sck rises -> no rx_valid_o, sdo_oe_o=0 within SYNC_STAGES+2 cycles; next full frame receives 8'hC3 correctly.
//  T5 Pull rst_n_i low mid-byte -> all outputs at reset values without a clk_i edge; the frame after release works as in T1.
//  T6 tx_valid_i with 8'h5A on the exact cs-fall load cycle, holding register empty -> MISO 8'h5A; no underrun; tx_ready_o stays 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI link constants and helpers used by both ends of the team's mode-0 SPI link.
package spi_pkg;

    localparam int unsigned SPI_WIDTH    = 8;
    localparam int unsigned SPI_BITCNT_W = 3;
    localparam logic [SPI_WIDTH-1:0] SPI_DEFAULT_FILL = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // MSB-first deserialiser step: the oldest bit ends up in the MSB.
    function automatic logic [SPI_WIDTH-1:0] spi_shift_in(
        input logic [SPI_WIDTH-1:0] cur,
        input logic                 bit_in
    );
        return {cur[SPI_WIDTH-2:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchroniser for one external pin, with edge pulses derived from the synchronised level.
module spi_pin_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign q      = chain_q[STAGES-1];
    assign rise_c = chain_q[STAGES-1] & ~prev_q;
    assign fall_c = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: oversampled pins, MOSI deserialiser, MISO serialiser with a one-byte
// holding register, byte-wide valid/ready core interface.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [SPI_WIDTH-1:0] TX_FILL     = SPI_DEFAULT_FILL
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 sck_i,
    input  logic                 cs_n_i,
    input  logic                 sdi_i,
    output logic                 sdo_o,
    output logic                 sdo_oe_o,
    input  logic [SPI_WIDTH-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [SPI_WIDTH-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 tx_underrun_o,
    output logic                 busy_o
);

    localparam logic [SPI_BITCNT_W-1:0] CNT_LAST = SPI_BITCNT_W'(SPI_WIDTH - 1);

    logic sck_q, sck_rise_c, sck_fall_c;
    logic cs_n_q, cs_rise_c, cs_fall_c;
    logic sdi_q, sdi_rise_unused, sdi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d       (sck_i),
        .q       (sck_q),
        .rise_c  (sck_rise_c),
        .fall_c  (sck_fall_c)
    );

    // cs_n idles high, so its rising edge ends a frame and its falling edge starts one
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d       (cs_n_i),
        .q       (cs_n_q),
        .rise_c  (cs_rise_c),
        .fall_c  (cs_fall_c)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d       (sdi_i),
        .q       (sdi_q),
        .rise_c  (sdi_rise_unused),
        .fall_c  (sdi_fall_unused)
    );

    spi_state_e             state_q, state_d;
    logic [SPI_BITCNT_W-1:0] cnt_q, cnt_d;
    logic [SPI_WIDTH-1:0]    rx_shift_q, rx_shift_d;
    logic [SPI_WIDTH-1:0]    tx_shift_q, tx_shift_d;
    logic [SPI_WIDTH-1:0]    hold_q, hold_d;
    logic                    frame_end_q, frame_end_d;
    logic                    sdo_d, sdo_oe_d, tx_ready_d, rx_valid_d, underrun_d, busy_d;
    logic [SPI_WIDTH-1:0]    rx_data_d, load_byte_c;
    logic                    load_c, wr_c;

    // tx_ready_o doubles as the "holding register empty" flag
    assign wr_c = tx_valid_i & tx_ready_o;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        frame_end_d = frame_end_q;
        sdo_d       = sdo_o;
        sdo_oe_d    = sdo_oe_o;
        tx_ready_d  = tx_ready_o;
        rx_data_d   = rx_data_o;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        load_c      = 1'b0;
        load_byte_c = TX_FILL;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_d     = ST_ACTIVE;
                    load_c      = 1'b1;
                    cnt_d       = CNT_LAST;
                    rx_shift_d  = '0;
                    frame_end_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // A CS rise wins over a coincident sck edge, so the trailing fall never reloads.
                if (cs_rise_c) begin
                    state_d     = ST_IDLE;
                    cnt_d       = CNT_LAST;
                    rx_shift_d  = '0;
                    tx_shift_d  = '0;
                    frame_end_d = 1'b0;
                    sdo_d       = 1'b0;
                    sdo_oe_d    = 1'b0;
                end else if (sck_rise_c) begin
                    rx_shift_d = spi_shift_in(rx_shift_q, sdi_q);
                    if (cnt_q == '0) begin
                        rx_data_d   = rx_shift_d;
                        rx_valid_d  = 1'b1;
                        cnt_d       = CNT_LAST;
                        frame_end_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - SPI_BITCNT_W'(1);
                    end
                end else if (sck_fall_c) begin
                    if (frame_end_q) begin
                        load_c      = 1'b1;
                        frame_end_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[SPI_WIDTH-2:0], 1'b0};
                        sdo_d      = tx_shift_q[SPI_WIDTH-2];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte source at a load: holding register, else same-cycle write, else the fill byte.
        if (load_c) begin
            if (!tx_ready_o) begin
                load_byte_c = hold_q;
                tx_ready_d  = 1'b1;
            end else if (wr_c) begin
                load_byte_c = tx_data_i;
            end else begin
                underrun_d = 1'b1;
            end
            tx_shift_d = load_byte_c;
            sdo_d      = load_byte_c[SPI_WIDTH-1];
            sdo_oe_d   = 1'b1;
        end else if (wr_c) begin
            hold_d     = tx_data_i;
            tx_ready_d = 1'b0;
        end

        busy_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_LAST;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            frame_end_q   <= 1'b0;
            sdo_o         <= 1'b0;
            sdo_oe_o      <= 1'b0;
            tx_ready_o    <= 1'b1;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            frame_end_q   <= frame_end_d;
            sdo_o         <= sdo_d;
            sdo_oe_o      <= sdo_oe_d;
            tx_ready_o    <= tx_ready_d;
            rx_data_o     <= rx_data_d;
            rx_valid_o    <= rx_valid_d;
            tx_underrun_o <= underrun_d;
            busy_o        <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: a bench-side SPI controller drives frames while monitors
// compare rx strobes, MISO bytes and underrun pulses against a byte-level model.
module tb_spi_peripheral;

    localparam int unsigned SYNC = 2;
    localparam logic [7:0]  FILL = 8'hFF;
    localparam int          HALF = 8;

    logic       clk_i      = 1'b0;
    logic       rst_n_i    = 1'b0;
    logic       sck_i      = 1'b0;
    logic       cs_n_i     = 1'b1;
    logic       sdi_i      = 1'b0;
    logic [7:0] tx_data_i  = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       sdo_o, sdo_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, busy_o;
    logic [7:0] rx_data_o;

    spi_peripheral #(.SYNC_STAGES(SYNC), .TX_FILL(FILL)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .sck_i         (sck_i),
        .cs_n_i        (cs_n_i),
        .sdi_i         (sdi_i),
        .sdo_o         (sdo_o),
        .sdo_oe_o      (sdo_oe_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_underrun_o (tx_underrun_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state and scoreboard queues
    logic [7:0] hold_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] miso_exp[$];
    logic [7:0] miso_obs[$];
    int         ur_exp = 0;
    int         ur_seen = 0;
    int         ur_cyc = 0;

    logic [7:0] f_mosi [4];
    bit         f_wr   [4];
    logic [7:0] f_wd   [4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Next byte on MISO: queued byte, else a write landing exactly at the load, else the fill byte.
    function automatic logic [7:0] model_load(input bit byp, input logic [7:0] byp_d);
        if (hold_q.size() > 0) return hold_q.pop_front();
        if (byp) return byp_d;
        ur_exp++;
        return FILL;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (tx_underrun_o) begin
            ur_seen++;
            ur_cyc = cyc;
        end
    end

    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            if (rx_exp.size() == 0) chk("rx_strobe_pending", rx_exp.size(), 1);
            else                    chk("rx_data", rx_data_o, rx_exp.pop_front());
        end
    end

    logic [7:0] mon_got;
    always @(negedge clk_i) begin
        if (miso_obs.size() > 0) begin
            mon_got = miso_obs.pop_front();
            if (miso_exp.size() == 0) chk("miso_pending", miso_exp.size(), 1);
            else                      chk("miso_byte", mon_got, miso_exp.pop_front());
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time %0t exceeds limit %0d", $time, 5000000);
        $fatal(1, "watchdog");
    end

    // One sck half period; optionally presents a tx write on its second cycle.
    task automatic half(input bit wr, input logic [7:0] d);
        for (int c = 0; c < HALF; c++) begin
            @(posedge clk_i); #1;
            tx_valid_i = wr && (c == 1);
            if (wr && c == 1) tx_data_i = d;
        end
    endtask

    task automatic tb_write(input logic [7:0] d);
        int w = 0;
        while (!tx_ready_o && w < 50) begin
            @(posedge clk_i); #1;
            w++;
        end
        chk("tx_ready_before_write", tx_ready_o, 1);
        tx_data_i = d; tx_valid_i = 1'b1;
        @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
        chk("tx_ready_after_write", tx_ready_o, 0);
        hold_q.push_back(d);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sdo"},      sdo_o, 0);
        chk({tag, "_sdo_oe"},   sdo_oe_o, 0);
        chk({tag, "_tx_ready"}, tx_ready_o, 1);
        chk({tag, "_rx_data"},  rx_data_o, 0);
        chk({tag, "_rx_valid"}, rx_valid_o, 0);
        chk({tag, "_underrun"}, tx_underrun_o, 0);
        chk({tag, "_busy"},     busy_o, 0);
    endtask

    task automatic end_checks();
        repeat (SYNC + 2) @(posedge clk_i);
        #1;
        chk("sdo_oe_after_cs", sdo_oe_o, 0);
        chk("sdo_after_cs", sdo_o, 0);
        chk("busy_after_cs", busy_o, 0);
        chk("underrun_count", ur_seen, ur_exp);
        repeat (10) @(posedge clk_i);
        #1;
    endtask

    // Controller side of one frame. stop_after>0 ends byte 0 early after that many rises,
    // by raising cs_n (by_reset=0) or by pulling rst_n_i low while sck is high (by_reset=1).
    task automatic run_frame(input int n, input int stop_after, input bit by_reset,
                             input bit byp, input logic [7:0] byp_d);
        logic [7:0] cur;
        logic [7:0] got;
        int rises = 0;
        int cs_cyc;
        int ur_before;
        got       = 8'h00;
        ur_before = ur_exp;
        cur = model_load(byp, byp_d);
        if (stop_after == 0) miso_exp.push_back(cur);
        sdi_i  = f_mosi[0][7];
        cs_n_i = 1'b0;
        cs_cyc = cyc;
        half(byp, byp_d);
        chk("busy_in_frame", busy_o, 1);
        chk("sdo_oe_in_frame", sdo_oe_o, 1);
        chk("underrun_count_at_start", ur_seen, ur_exp);
        if (ur_exp != ur_before)
            chk("underrun_latency_ok", 32'((ur_cyc - cs_cyc) <= int'(SYNC) + 2), 1);
        if (byp) chk("tx_ready_after_bypass", tx_ready_o, 1);
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                got[b] = sdo_o;
                sck_i  = 1'b1;
                rises++;
                if (b == 0) rx_exp.push_back(f_mosi[i]);
                if (stop_after != 0 && rises == stop_after) begin
                    if (by_reset) begin
                        #2 rst_n_i = 1'b0;
                        #1 chk_reset_outputs("async_reset");
                        cs_n_i = 1'b1; sck_i = 1'b0;
                        hold_q.delete();
                        repeat (3) @(posedge clk_i);
                        #2 rst_n_i = 1'b1;
                        repeat (10) @(posedge clk_i);
                        #1;
                    end else begin
                        half(1'b0, 8'h00);
                        sck_i = 1'b0;
                        half(1'b0, 8'h00);
                        cs_n_i = 1'b1;
                        end_checks();
                    end
                    return;
                end
                half(f_wr[i] && b == 4, f_wd[i]);
                if (f_wr[i] && b == 4) hold_q.push_back(f_wd[i]);
                sck_i = 1'b0;
                if (i == n - 1 && b == 0) begin
                    cs_n_i = 1'b1;
                    miso_obs.push_back(got);
                end else begin
                    if (b > 0) sdi_i = f_mosi[i][b-1];
                    else begin
                        sdi_i = f_mosi[i+1][7];
                        miso_obs.push_back(got);
                        cur = model_load(1'b0, 8'h00);
                        miso_exp.push_back(cur);
                    end
                    half(1'b0, 8'h00);
                end
            end
        end
        end_checks();
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 4; i++) begin
            f_mosi[i] = 8'h00; f_wr[i] = 1'b0; f_wd[i] = 8'h00;
        end
    endtask

    int         rn;
    bit         rbyp;
    logic [7:0] rbd;

    initial begin
        clear_frame();
        repeat (3) @(posedge clk_i);
        #1 chk_reset_outputs("reset");
        rst_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;

        // T1: pre-written A5 while controller sends 3C
        clear_frame(); f_mosi[0] = 8'h3C;
        tb_write(8'hA5);
        run_frame(1, 0, 1'b0, 1'b0, 8'h00);

        // T2: nothing queued -> fill byte and one underrun near cs fall
        clear_frame(); f_mosi[0] = 8'h96;
        run_frame(1, 0, 1'b0, 1'b0, 8'h00);

        // T3: two-byte burst, second tx byte written during byte one
        clear_frame(); f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_wr[0] = 1'b1; f_wd[0] = 8'h22;
        tb_write(8'h11);
        run_frame(2, 0, 1'b0, 1'b0, 8'h00);

        // T4: abort after five rises, then a clean frame
        clear_frame(); f_mosi[0] = 8'hE7;
        run_frame(1, 5, 1'b0, 1'b0, 8'h00);
        clear_frame(); f_mosi[0] = 8'hC3;
        run_frame(1, 0, 1'b0, 1'b0, 8'h00);

        // T5: reset mid-byte, then a T1-style frame
        clear_frame(); f_mosi[0] = 8'h5F;
        tb_write(8'h77);
        run_frame(1, 3, 1'b1, 1'b0, 8'h00);
        clear_frame(); f_mosi[0] = 8'h3C;
        tb_write(8'hA5);
        run_frame(1, 0, 1'b0, 1'b0, 8'h00);

        // T6: write presented on the exact cs-fall load cycle
        clear_frame(); f_mosi[0] = 8'h81;
        run_frame(1, 0, 1'b0, 1'b1, 8'h5A);

        // randomised bursts
        for (int k = 0; k < 8; k++) begin
            rn   = int'($urandom_range(1, 3));
            rbyp = 1'b0;
            rbd  = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                f_mosi[i] = 8'($urandom);
                f_wr[i]   = 1'($urandom_range(0, 1));
                f_wd[i]   = 8'($urandom);
            end
            if (hold_q.size() == 0) begin
                case ($urandom_range(0, 2))
                    0:       tb_write(8'($urandom));
                    1:       rbyp = 1'b1;
                    default: ;
                endcase
            end
            run_frame(rn, 0, 1'b0, rbyp, rbd);
        end

        repeat (20) @(posedge clk_i);
        #1;
        chk("rx_queue_drained", rx_exp.size(), 0);
        chk("miso_queue_drained", miso_exp.size(), 0);
        chk("underrun_total", ur_seen, ur_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
